vid_fetch_ctrl: RTL



---
 rtl/vid_timing_pkg.sv | 31 +++
 rtl/vid_sync_gen.sv | 49 ++++
 rtl/vid_fetch_ctrl.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/vid_timing_pkg.sv
// 1080p60 timing constants, derived window edges and fetch FSM encoding.
// Shared by the sync decoder and the line-fetch controller.
package vid_timing_pkg;

    localparam int SYNC_H   = 44;
    localparam int BP_H     = 148;
    localparam int ACTIVE_H = 1920;
    localparam int TOTAL_H  = 2200;
    localparam int SYNC_V   = 5;
    localparam int BP_V     = 36;
    localparam int ACTIVE_V = 1080;
    localparam int TOTAL_V  = 1125;

    localparam int BURST_LEN   = 64;
    localparam int ADDR_W      = 24;
    localparam int LINE_STRIDE = 1920;

    localparam int H_ACT           = SYNC_H + BP_H;
    localparam int V_ACT           = SYNC_V + BP_V;
    localparam int BURSTS_PER_LINE = ACTIVE_H / BURST_LEN;
    localparam int BCNT_W          = $clog2(BURSTS_PER_LINE);

    localparam logic [ADDR_W-1:0] STRIDE_A = ADDR_W'(LINE_STRIDE);
    localparam logic [ADDR_W-1:0] BURST_A  = ADDR_W'(BURST_LEN);

    typedef logic [1:0] fetch_state_t;
    localparam fetch_state_t ST_IDLE = 2'd0;
    localparam fetch_state_t ST_REQ  = 2'd1;
    localparam fetch_state_t ST_NEXT = 2'd2;

endpackage

// File: rtl/vid_sync_gen.sv
// Registered hsync/vsync/de decode from the free-running h/v counters.
// Latency: 1 clk after hcnt/vcnt. Backpressure: none, runs every cycle.
module vid_sync_gen
    import vid_timing_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [11:0] hcnt,
    input  logic [10:0] vcnt,
    output logic        hsync,
    output logic        vsync,
    output logic        de
);

    localparam logic [11:0] H_SYNC_END = 12'(SYNC_H);
    localparam logic [11:0] H_DE_BEG   = 12'(H_ACT);
    localparam logic [11:0] H_DE_END   = 12'(H_ACT + ACTIVE_H);
    localparam logic [10:0] V_SYNC_END = 11'(SYNC_V);
    localparam logic [10:0] V_DE_BEG   = 11'(V_ACT);
    localparam logic [10:0] V_DE_END   = 11'(V_ACT + ACTIVE_V);

    logic hsync_q, hsync_d;
    logic vsync_q, vsync_d;
    logic de_q, de_d;

    always_comb begin
        hsync_d = (hcnt < H_SYNC_END);
        vsync_d = (vcnt < V_SYNC_END);
        de_d    = (hcnt >= H_DE_BEG) && (hcnt < H_DE_END) &&
                  (vcnt >= V_DE_BEG) && (vcnt < V_DE_END);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hsync_q <= 1'b0;
            vsync_q <= 1'b0;
            de_q    <= 1'b0;
        end else begin
            hsync_q <= hsync_d;
            vsync_q <= vsync_d;
            de_q    <= de_d;
        end
    end

    assign hsync = hsync_q;
    assign vsync = vsync_q;
    assign de    = de_q;

endmodule

// File: rtl/vid_fetch_ctrl.sv
// Video output controller: sync/de decode plus one-line-ahead burst fetch scheduling.
// Latency: sync/de 1 clk after counters; first rd_req 1 clk after the line trigger.
// Backpressure: rd_req/rd_addr held until rd_ack; a fetch still running at the next trigger flags underflow.
module vid_fetch_ctrl
    import vid_timing_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic [11:0]       hcnt,
    input  logic [10:0]       vcnt,
    input  logic              enable,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic              clr_underflow,
    output logic              rd_req,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic              rd_ack,
    output logic              hsync,
    output logic              vsync,
    output logic              de,
    output logic              fetch_busy,
    output logic              underflow
);

    localparam logic [11:0]       H_LAST       = 12'(TOTAL_H - 1);
    localparam logic [10:0]       V_LAST       = 11'(TOTAL_V - 1);
    localparam logic [10:0]       V_TRIG_FIRST = 11'(V_ACT - 1);
    localparam logic [10:0]       V_TRIG_LAST  = 11'(V_ACT + ACTIVE_V - 2);
    localparam logic [BCNT_W-1:0] BCNT_LAST    = BCNT_W'(BURSTS_PER_LINE - 1);

    fetch_state_t      state_q, state_d;
    logic [ADDR_W-1:0] line_ptr_q, line_ptr_d;
    logic [ADDR_W-1:0] burst_addr_q, burst_addr_d;
    logic [BCNT_W-1:0] bcnt_q, bcnt_d;
    logic              pend_q, pend_d;
    logic              underflow_q, underflow_d;

    logic              line_trig;
    logic              frame_wrap;
    logic              uf_set;
    logic              start_line;
    logic [ADDR_W-1:0] start_addr;

    vid_sync_gen u_sync (
        .clk   (clk),
        .reset (reset),
        .hcnt  (hcnt),
        .vcnt  (vcnt),
        .hsync (hsync),
        .vsync (vsync),
        .de    (de)
    );

    // Trigger on the line before each active line so the fetch has a full line of lead.
    assign line_trig  = (hcnt == '0) && (vcnt >= V_TRIG_FIRST) && (vcnt <= V_TRIG_LAST);
    assign frame_wrap = (hcnt == H_LAST) && (vcnt == V_LAST);

    always_comb begin
        state_d      = state_q;
        line_ptr_d   = line_ptr_q;
        burst_addr_d = burst_addr_q;
        bcnt_d       = bcnt_q;
        pend_d       = pend_q;
        uf_set       = 1'b0;
        start_line   = 1'b0;
        start_addr   = line_ptr_q;

        // line_ptr advances on every trigger, fetched or not, so addresses track the raster.
        if (frame_wrap) begin
            line_ptr_d = base_addr;
        end else if (line_trig) begin
            line_ptr_d = line_ptr_q + STRIDE_A;
        end

        case (state_q)
            ST_REQ: begin
                if (line_trig && enable) begin
                    uf_set = 1'b1;
                    if (rd_ack) begin
                        start_line = 1'b1;
                    end else begin
                        pend_d = 1'b1;
                    end
                end else if (rd_ack) begin
                    if (!enable) begin
                        state_d = ST_IDLE;
                        pend_d  = 1'b0;
                    end else if (pend_q) begin
                        // line_ptr already stepped past the pending line at its trigger.
                        start_line = 1'b1;
                        start_addr = line_ptr_q - STRIDE_A;
                    end else begin
                        state_d = ST_NEXT;
                    end
                end
            end
            ST_NEXT: begin
                burst_addr_d = burst_addr_q + BURST_A;
                bcnt_d       = bcnt_q + 1'b1;
                if (line_trig && enable) begin
                    uf_set     = 1'b1;
                    start_line = 1'b1;
                end else if (!enable || (bcnt_q == BCNT_LAST)) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_REQ;
                end
            end
            default: begin
                state_d = ST_IDLE;
                if (line_trig && enable) begin
                    start_line = 1'b1;
                end
            end
        endcase

        if (start_line) begin
            burst_addr_d = start_addr;
            bcnt_d       = '0;
            pend_d       = 1'b0;
            state_d      = ST_REQ;
        end

        if (uf_set) begin
            underflow_d = 1'b1;
        end else if (clr_underflow) begin
            underflow_d = 1'b0;
        end else begin
            underflow_d = underflow_q;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            line_ptr_q   <= '0;
            burst_addr_q <= '0;
            bcnt_q       <= '0;
            pend_q       <= 1'b0;
            underflow_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            line_ptr_q   <= line_ptr_d;
            burst_addr_q <= burst_addr_d;
            bcnt_q       <= bcnt_d;
            pend_q       <= pend_d;
            underflow_q  <= underflow_d;
        end
    end

    assign rd_req     = (state_q == ST_REQ);
    assign rd_addr    = burst_addr_q;
    assign fetch_busy = (state_q != ST_IDLE) || pend_q;
    assign underflow  = underflow_q;

endmodule
